// File: rtl/rpsc_interlock_card_pkg.sv
// rpsc_pkg: shared types and helpers for the RPSC interlock card.
//   ff_state_e  - first-fault capture states (IDLE, CAPTURED)
//   clog2_min1  - index width for a count of items, never below one bit
package rpsc_pkg;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    CAPTURED = 1'b1
  } ff_state_e;

  // Bits needed to index 'value' items; a single item still gets one bit.
  function automatic int clog2_min1(input int value);
    int width;
    if (value > 1) begin
      width = $clog2(value);
    end else begin
      width = 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/rpsc_interlock_card_if.sv
// rpsc_interlock_card_if: card-level signal bundle between the raw inputs,
// the operator acknowledge and the front-panel lamps / trip chain.
//   fault_in      raw asynchronous fault inputs (N_CH)
//   ack_in        operator acknowledge, level
//   trip_out      latched per-channel trips (N_CH)
//   lamp_out      per-channel indicator lamps (N_CH)
//   emergency_out OR of all trips
//   ff_valid      first fault captured
//   ff_id         first-fault channel index
// Modports: slave = the card, master = whatever drives the card.
interface rpsc_interlock_card_if
  import rpsc_pkg::*;
#(
  parameter int N_CH = 8
);
  localparam int ID_W = clog2_min1(N_CH);

  logic [N_CH-1:0] fault_in;
  logic            ack_in;
  logic [N_CH-1:0] trip_out;
  logic [N_CH-1:0] lamp_out;
  logic            emergency_out;
  logic            ff_valid;
  logic [ID_W-1:0] ff_id;

  modport master (
    output fault_in, ack_in,
    input  trip_out, lamp_out, emergency_out, ff_valid, ff_id
  );

  modport slave (
    input  fault_in, ack_in,
    output trip_out, lamp_out, emergency_out, ff_valid, ff_id
  );
endinterface

// File: rtl/rpsc_interlock_card_debounce.sv
// rpsc_chan_debounce: front end of one fault channel - 2-FF synchroniser,
// polarity correction and a saturating run-length counter.
//   clk       system clock
//   reset     asynchronous active-low reset
//   fault_in  raw asynchronous fault input
//   qual      high on every edge at which the counter sits at (or is just
//             reaching) DEB_CYCLES, so a registered trip lands on the same
//             edge the counter saturates
module rpsc_chan_debounce #(
  parameter int DEB_CYCLES = 16,
  parameter bit INV        = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic fault_in,
  output logic qual
);
  localparam int               CNT_W   = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             act_s;
  logic [CNT_W-1:0] cnt_r;

  // Two-stage synchroniser for the asynchronous raw input
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= fault_in;
      sync2_r <= sync1_r;
    end
  end

  assign act_s = sync2_r ^ INV;

  // Consecutive-active counter, saturating at DEB_CYCLES, cleared on inactive
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (!act_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_r != CNT_MAX) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Equivalent to "next count == DEB_CYCLES": the trip register samples this
  // term, which keeps fault-edge to trip latency at 2 + DEB_CYCLES edges.
  assign qual = act_s && (cnt_r >= CNT_PRE);

endmodule

// File: rtl/rpsc_interlock_card.sv
// rpsc_interlock_card: N_CH-channel RPSC interlock card.
// Per channel: synchronise, correct polarity, debounce, latch a trip and
// drive a lamp. Card level: emergency summary, first-fault capture with a
// blinking first-fault lamp. Trips clear only on operator acknowledge.
//   clk           system clock
//   reset         asynchronous active-low reset
//   lamp_test_in  all lamps on while high (only with RPSC_LAMP_TEST_EN)
//   bus           rpsc_interlock_card_if.slave: fault_in, ack_in in;
//                 trip_out, lamp_out, emergency_out, ff_valid, ff_id out
// Build option: define RPSC_LAMP_TEST_EN to add the lamp_test_in port.
module rpsc_interlock_card
  import rpsc_pkg::*;
#(
  parameter int              N_CH       = 8,
  parameter int              DEB_CYCLES = 16,
  parameter logic [N_CH-1:0] INV_MASK   = {N_CH{1'b0}},
  parameter int              BLINK_HALF = 2**20
) (
  input  logic clk,
  input  logic reset,
`ifdef RPSC_LAMP_TEST_EN
  input  logic lamp_test_in,
`endif
  rpsc_interlock_card_if.slave bus
);
  localparam int               ID_W     = clog2_min1(N_CH);
  localparam int               BLK_W    = clog2_min1(BLINK_HALF);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_HALF - 1);

  logic [N_CH-1:0]  qual_s;
  logic [N_CH-1:0]  trip_next_s;
  logic [N_CH-1:0]  lamp_next_s;
  logic [ID_W-1:0]  low_id_s;
  logic             lamp_test_s;
  logic [N_CH-1:0]  trip_r;
  logic [N_CH-1:0]  lamp_r;
  logic             emergency_r;
  logic             ff_valid_r;
  logic [ID_W-1:0]  ff_id_r;
  ff_state_e        state_r;
  logic [BLK_W-1:0] blink_cnt_r;
  logic             blink_r;

  for (genvar i = 0; i < N_CH; i++) begin : gen_ch
    rpsc_chan_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .INV        (INV_MASK[i])
    ) u_deb (
      .clk      (clk),
      .reset    (reset),
      .fault_in (bus.fault_in[i]),
      .qual     (qual_s[i])
    );
  end

`ifdef RPSC_LAMP_TEST_EN
  assign lamp_test_s = lamp_test_in;
`else
  assign lamp_test_s = 1'b0;
`endif

  // Next trip vector: a qualifying channel always sets (so it beats ack);
  // ack drops every latched channel that is no longer qualifying.
  always_comb begin
    trip_next_s = qual_s;
    if (bus.ack_in) begin
      trip_next_s = qual_s;
    end else begin
      trip_next_s = qual_s | trip_r;
    end
  end

  // Lowest qualifying index; scanning downwards lets the lowest hit win
  always_comb begin
    low_id_s = {ID_W{1'b0}};
    for (int i = N_CH - 1; i >= 0; i--) begin
      low_id_s = qual_s[i] ? ID_W'(i) : low_id_s;
    end
  end

  // Lamp pattern: first-fault channel blinks, other tripped channels steady
  always_comb begin
    lamp_next_s = {N_CH{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      if (ff_valid_r && (ff_id_r == ID_W'(i))) begin
        lamp_next_s[i] = blink_r;
      end else begin
        lamp_next_s[i] = trip_r[i];
      end
    end
  end

  // Trip latches and emergency summary
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trip_r      <= {N_CH{1'b0}};
      emergency_r <= 1'b0;
    end else begin
      trip_r      <= trip_next_s;
      emergency_r <= |trip_next_s;
    end
  end

  // First-fault capture FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      ff_valid_r <= 1'b0;
      ff_id_r    <= {ID_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if ((trip_r == {N_CH{1'b0}}) && (qual_s != {N_CH{1'b0}})) begin
            state_r    <= CAPTURED;
            ff_valid_r <= 1'b1;
            ff_id_r    <= low_id_s;
          end
        end
        CAPTURED: begin
          // Leave only once the acknowledge really empties the trip vector
          if (bus.ack_in && (trip_next_s == {N_CH{1'b0}})) begin
            state_r    <= IDLE;
            ff_valid_r <= 1'b0;
            ff_id_r    <= {ID_W{1'b0}};
          end
        end
        default: begin
          state_r    <= IDLE;
          ff_valid_r <= 1'b0;
          ff_id_r    <= {ID_W{1'b0}};
        end
      endcase
    end
  end

  // Free-running blink timebase, toggling the blink phase at each wrap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt_r <= {BLK_W{1'b0}};
      blink_r     <= 1'b0;
    end else if (blink_cnt_r == BLK_LAST) begin
      blink_cnt_r <= {BLK_W{1'b0}};
      blink_r     <= ~blink_r;
    end else begin
      blink_cnt_r <= blink_cnt_r + BLK_W'(1);
    end
  end

  // Registered lamp drive; lamp test overrides the pattern only
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lamp_r <= {N_CH{1'b0}};
    end else if (lamp_test_s) begin
      lamp_r <= {N_CH{1'b1}};
    end else begin
      lamp_r <= lamp_next_s;
    end
  end

  assign bus.trip_out      = trip_r;
  assign bus.lamp_out      = lamp_r;
  assign bus.emergency_out = emergency_r;
  assign bus.ff_valid      = ff_valid_r;
  assign bus.ff_id         = ff_id_r;

endmodule

// File: tb/tb_rpsc_interlock_card.sv
// Bench for rpsc_interlock_card: N_CH=8, DEB_CYCLES=4, INV_MASK=8'h01,
// BLINK_HALF=8. Channel 0 is active-low, so "all quiet" on fault_in is 8'h01.
module tb_rpsc_interlock_card;
  localparam int         N_CH    = 8;
  localparam int         DEB     = 4;
  localparam int         BH      = 8;
  localparam logic [7:0] INV     = 8'h01;
  localparam logic [7:0] IDLE_IN = 8'h01;

  logic clk = 1'b0;
  logic reset;
`ifdef RPSC_LAMP_TEST_EN
  logic lamp_test_in;
`endif

  rpsc_interlock_card_if #(.N_CH(N_CH)) bus();

  rpsc_interlock_card #(
    .N_CH       (N_CH),
    .DEB_CYCLES (DEB),
    .INV_MASK   (INV),
    .BLINK_HALF (BH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
`ifdef RPSC_LAMP_TEST_EN
    .lamp_test_in (lamp_test_in),
`endif
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: card behaviour stated directly from the rules
  logic [7:0] samp_q[$];   // fault_in samples, prefixed by the cleared synchroniser
  logic [7:0] act_q[$];    // last DEB "active" vectors seen by the debounce
  logic [7:0] m_trip, m_lamp;
  logic       m_emerg, m_ffv;
  logic [2:0] m_ffid;
  int         m_edges;

  task automatic model_reset();
    samp_q = {8'h00, 8'h00};
    act_q.delete();
    m_trip = 8'h00; m_lamp = 8'h00; m_emerg = 1'b0; m_ffv = 1'b0;
    m_ffid = 3'd0; m_edges = 0;
  endtask

  function automatic logic [20:0] dut_vec();
    return {bus.trip_out, bus.lamp_out, bus.emergency_out, bus.ff_valid, bus.ff_id};
  endfunction

  function automatic logic [20:0] mdl_vec();
    return {m_trip, m_lamp, m_emerg, m_ffv, m_ffid};
  endfunction

  // Apply one cycle of inputs, clock once, advance the model, settle
  task automatic step(input logic [7:0] f, input logic ack, input logic lt);
    logic [7:0] act, qual, trip_new, lamp_new;
    logic       blink_old, lt_eff;
    bus.fault_in = f;
    bus.ack_in   = ack;
`ifdef RPSC_LAMP_TEST_EN
    lamp_test_in = lt;
    lt_eff = lt;
`else
    lt_eff = 1'b0;
`endif
    @(posedge clk);
    act = samp_q[samp_q.size() - 2] ^ INV;   // value sampled two edges ago
    samp_q.push_back(f);
    if (samp_q.size() > 3) void'(samp_q.pop_front());
    act_q.push_back(act);
    if (act_q.size() > DEB) void'(act_q.pop_front());
    // qualified = active on each of the last DEB edges
    qual = (act_q.size() == DEB) ? 8'hFF : 8'h00;
    foreach (act_q[k]) qual &= act_q[k];
    blink_old = ((m_edges / BH) % 2) == 1;
    for (int i = 0; i < 8; i++)
      lamp_new[i] = (m_ffv && m_ffid == 3'(i)) ? blink_old : m_trip[i];
    if (lt_eff) lamp_new = 8'hFF;
    trip_new = qual | (ack ? 8'h00 : m_trip);
    if (!m_ffv) begin
      if (m_trip == 8'h00 && qual != 8'h00) begin
        m_ffv = 1'b1;
        for (int i = 7; i >= 0; i--) if (qual[i]) m_ffid = 3'(i);
      end
    end else if (ack && trip_new == 8'h00) begin
      m_ffv = 1'b0; m_ffid = 3'd0;
    end
    m_trip = trip_new; m_emerg = |trip_new; m_lamp = lamp_new;
    m_edges++;
    #1;
  endtask

  task automatic clear_all();
    for (int c = 0; c < 6; c++) step(IDLE_IN, 1'b0, 1'b0);
    step(IDLE_IN, 1'b1, 1'b0);
    step(IDLE_IN, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    #3 reset = 1'b0;
    model_reset();
    #1;
    n_assert++;
    if (dut_vec() !== 21'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected %h", dut_vec(), 21'd0);
    end
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    // ch0 reads active for two edges straight out of reset; must not trip
    for (int c = 0; c < 6; c++) begin
      step(IDLE_IN, 1'b0, 1'b0);
      n_assert++;
      if (dut_vec() !== 21'd0) begin
        n_fail++; $display("FAIL reset_idle: cycle %0d got %h expected %h", c, dut_vec(), 21'd0);
      end
    end
  endtask

  task automatic test_short_pulse();
    for (int c = 0; c < 12; c++) begin
      step((c < 3) ? (IDLE_IN | 8'h08) : IDLE_IN, 1'b0, 1'b0);
      n_assert++;
      if ({bus.trip_out, bus.emergency_out} !== 9'd0) begin
        n_fail++; $display("FAIL short_pulse: cycle %0d trip %h emerg %b expected 00/0", c, bus.trip_out, bus.emergency_out);
      end
    end
  endtask

  task automatic test_latency();
    for (int c = 1; c <= 10; c++) begin
      step(IDLE_IN | 8'h08, 1'b0, 1'b0);
      if (c == 5) begin
        n_assert++;
        if (bus.trip_out !== 8'h00) begin
          n_fail++; $display("FAIL latency_early: got %h expected 00", bus.trip_out);
        end
      end
      if (c == 6) begin
        n_assert++;
        if ({bus.trip_out, bus.emergency_out, bus.ff_valid, bus.ff_id} !== {8'h08, 1'b1, 1'b1, 3'd3}) begin
          n_fail++; $display("FAIL latency_trip: got trip %h em %b v %b id %0d expected 08/1/1/3",
                             bus.trip_out, bus.emergency_out, bus.ff_valid, bus.ff_id);
        end
      end
      n_assert++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL latency_model: cycle %0d got %h expected %h", c, dut_vec(), mdl_vec());
      end
    end
    for (int c = 0; c < 6; c++) step(IDLE_IN, 1'b0, 1'b0);
    n_assert++;
    if (bus.trip_out !== 8'h08) begin
      n_fail++; $display("FAIL latency_hold: got %h expected 08", bus.trip_out);
    end
    step(IDLE_IN, 1'b1, 1'b0);
    n_assert++;
    if ({bus.trip_out, bus.emergency_out, bus.ff_valid} !== 10'd0) begin
      n_fail++; $display("FAIL latency_ack: got trip %h em %b v %b expected 00/0/0", bus.trip_out, bus.emergency_out, bus.ff_valid);
    end
    step(IDLE_IN, 1'b0, 1'b0);
  endtask

  task automatic test_simultaneous();
    int hi = 0, lo = 0;
    for (int c = 0; c < 6; c++) step(IDLE_IN | 8'h24, 1'b0, 1'b0);
    n_assert++;
    if ({bus.trip_out, bus.ff_valid, bus.ff_id} !== {8'h24, 1'b1, 3'd2}) begin
      n_fail++; $display("FAIL simult_capture: got trip %h v %b id %0d expected 24/1/2", bus.trip_out, bus.ff_valid, bus.ff_id);
    end
    for (int c = 0; c < 24; c++) begin
      step(IDLE_IN | 8'h24, 1'b0, 1'b0);
      if (bus.lamp_out[2]) hi++; else lo++;
      n_assert++;
      if (bus.lamp_out[5] !== 1'b1 || bus.lamp_out !== m_lamp) begin
        n_fail++; $display("FAIL simult_lamp: cycle %0d got %h expected %h", c, bus.lamp_out, m_lamp);
      end
    end
    n_assert++;
    if (hi == 0 || lo == 0) begin
      n_fail++; $display("FAIL simult_blink: lamp2 high %0d low %0d expected both nonzero", hi, lo);
    end
    clear_all();
  endtask

  task automatic test_ff_hold();
    for (int c = 0; c < 6; c++) step(IDLE_IN | 8'h02, 1'b0, 1'b0);
    for (int c = 0; c < 8; c++) step(IDLE_IN | 8'h42, 1'b0, 1'b0);
    n_assert++;
    if ({bus.trip_out, bus.ff_id} !== {8'h42, 3'd1}) begin
      n_fail++; $display("FAIL ffhold_second: got trip %h id %0d expected 42/1", bus.trip_out, bus.ff_id);
    end
    for (int c = 0; c < 5; c++) step(IDLE_IN | 8'h40, 1'b0, 1'b0);
    step(IDLE_IN | 8'h40, 1'b1, 1'b0);
    n_assert++;
    if ({bus.trip_out, bus.ff_valid, bus.ff_id} !== {8'h40, 1'b1, 3'd1}) begin
      n_fail++; $display("FAIL ffhold_ack_active: got trip %h v %b id %0d expected 40/1/1", bus.trip_out, bus.ff_valid, bus.ff_id);
    end
    for (int c = 0; c < 5; c++) step(IDLE_IN, 1'b0, 1'b0);
    step(IDLE_IN, 1'b1, 1'b0);
    n_assert++;
    if ({bus.trip_out, bus.emergency_out, bus.ff_valid, bus.ff_id} !== 13'd0) begin
      n_fail++; $display("FAIL ffhold_clear: got trip %h em %b v %b id %0d expected all 0",
                         bus.trip_out, bus.emergency_out, bus.ff_valid, bus.ff_id);
    end
    // Back in IDLE: a fresh fault must be captured again
    for (int c = 0; c < 6; c++) step(IDLE_IN | 8'h80, 1'b0, 1'b0);
    n_assert++;
    if ({bus.ff_valid, bus.ff_id} !== {1'b1, 3'd7}) begin
      n_fail++; $display("FAIL ffhold_recapture: got v %b id %0d expected 1/7", bus.ff_valid, bus.ff_id);
    end
    clear_all();
  endtask

  task automatic test_ack_set_wins();
    // fault_in[0]=0 is the active level on the inverted channel
    for (int c = 1; c <= 9; c++) begin
      step(8'h00, 1'b1, 1'b0);
      if (c == 5) begin
        n_assert++;
        if (bus.trip_out !== 8'h00) begin
          n_fail++; $display("FAIL setwins_early: got %h expected 00", bus.trip_out);
        end
      end
      if (c >= 6) begin
        n_assert++;
        if ({bus.trip_out, bus.emergency_out, bus.ff_valid, bus.ff_id} !== {8'h01, 1'b1, 1'b1, 3'd0}) begin
          n_fail++; $display("FAIL setwins_trip: cycle %0d got trip %h em %b v %b id %0d expected 01/1/1/0",
                             c, bus.trip_out, bus.emergency_out, bus.ff_valid, bus.ff_id);
        end
      end
    end
    for (int c = 0; c < 6; c++) step(IDLE_IN, 1'b1, 1'b0);
    n_assert++;
    if ({bus.trip_out, bus.emergency_out, bus.ff_valid} !== 10'd0) begin
      n_fail++; $display("FAIL setwins_clear: got trip %h em %b v %b expected 00/0/0", bus.trip_out, bus.emergency_out, bus.ff_valid);
    end
    step(IDLE_IN, 1'b0, 1'b0);
  endtask

  task automatic test_lamp_test();
`ifdef RPSC_LAMP_TEST_EN
    for (int c = 0; c < 6; c++) step(8'h00, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step(8'h00, 1'b0, 1'b1);
      n_assert++;
      if ({bus.lamp_out, bus.trip_out, bus.ff_valid, bus.ff_id} !== {8'hFF, 8'h01, 1'b1, 3'd0}) begin
        n_fail++; $display("FAIL lamptest_on: got lamp %h trip %h v %b id %0d expected FF/01/1/0",
                           bus.lamp_out, bus.trip_out, bus.ff_valid, bus.ff_id);
      end
    end
    step(8'h00, 1'b0, 1'b0);
    n_assert++;
    if (bus.lamp_out !== m_lamp || (bus.lamp_out & 8'hFE) !== 8'h00) begin
      n_fail++; $display("FAIL lamptest_off: got %h expected %h", bus.lamp_out, m_lamp);
    end
    clear_all();
`endif
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 3; c++) step(IDLE_IN | 8'h10, 1'b0, 1'b0);
    #2 reset = 1'b0;
    model_reset();
    #1;
    @(negedge clk);
    reset = 1'b1;
    // Debounce restarts from zero: full 2+DEB edges again
    for (int c = 1; c <= 6; c++) begin
      step(IDLE_IN | 8'h10, 1'b0, 1'b0);
      if (c == 5) begin
        n_assert++;
        if (bus.trip_out !== 8'h00) begin
          n_fail++; $display("FAIL areset_debounce: got %h expected 00", bus.trip_out);
        end
      end
    end
    n_assert++;
    if (bus.trip_out !== 8'h10) begin
      n_fail++; $display("FAIL areset_retrip: got %h expected 10", bus.trip_out);
    end
    step(IDLE_IN | 8'h10, 1'b0, 1'b0);
    #2 reset = 1'b0;
    model_reset();
    #1;
    n_assert++;
    if (dut_vec() !== 21'd0) begin
      n_fail++; $display("FAIL areset_midtrip: got %h expected %h", dut_vec(), 21'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step(IDLE_IN, 1'b0, 1'b0);
      n_assert++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL areset_after: got %h expected %h", dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] f = IDLE_IN;
    logic       ack, lt;
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 11) == 0) f[b] = ~f[b];
      ack = ($urandom_range(0, 9) == 0);
      lt  = ($urandom_range(0, 15) == 0);
      step(f, ack, lt);
      n_assert++;
      if (bus.trip_out !== m_trip) begin
        n_fail++; $display("FAIL rand_trip: cycle %0d got %h expected %h", c, bus.trip_out, m_trip);
      end
      n_assert++;
      if (bus.lamp_out !== m_lamp) begin
        n_fail++; $display("FAIL rand_lamp: cycle %0d got %h expected %h", c, bus.lamp_out, m_lamp);
      end
      n_assert++;
      if (bus.emergency_out !== m_emerg) begin
        n_fail++; $display("FAIL rand_emerg: cycle %0d got %b expected %b", c, bus.emergency_out, m_emerg);
      end
      n_assert++;
      if ({bus.ff_valid, bus.ff_id} !== {m_ffv, m_ffid}) begin
        n_fail++; $display("FAIL rand_ff: cycle %0d got %b/%0d expected %b/%0d", c, bus.ff_valid, bus.ff_id, m_ffv, m_ffid);
      end
    end
  endtask

  initial begin
    reset        = 1'b1;
    bus.fault_in = IDLE_IN;
    bus.ack_in   = 1'b0;
`ifdef RPSC_LAMP_TEST_EN
    lamp_test_in = 1'b0;
`endif
    model_reset();
    test_reset();
    test_short_pulse();
    test_latency();
    test_simultaneous();
    test_ff_hold();
    test_ack_set_wins();
    test_lamp_test();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rpsc_interlock_card.md
Name: rpsc_interlock_card

Overview:
Parametrised successor to the fixed 8-channel RPSC interlock cards. It provides N_CH fault channels, each with:
- input synchronisation, per-channel polarity and debounce;
- a latched trip output and an indicator lamp.

It also provides an emergency summary output and first-fault capture with a blinking first-fault lamp. Trips clear only on an operator acknowledge. The block sits between the raw card inputs and the RPSC front-panel lamps and trip chain.

Parameters:
N_CH, 8, number of fault channels (2..32)
DEB_CYCLES, 16, consecutive asserted cycles required to qualify a fault (>=1)
INV_MASK, 0, N_CH-bit mask; bit=1 means that channel's raw input is active-low
BLINK_HALF, 2**20, clk cycles per half-period of the first-fault lamp blink

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
fault_in  in  N_CH  raw asynchronous fault inputs
ack_in  in  1  operator acknowledge/reset, synchronous, level
trip_out  out  N_CH  latched per-channel trip
lamp_out  out  N_CH  per-channel indicator lamp
emergency_out  out  1  OR of all trip_out bits
ff_valid  out  1  first fault has been captured
ff_id  out  $clog2(N_CH)  index of the first-fault channel

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, all counters 0, FSM in IDLE, synchronisers cleared.
- Input path: 2-FF synchroniser per channel, then XOR with INV_MASK to give act[i].
- Debounce: per-channel counter.
  - act[i]=1 increments the counter, saturating at DEB_CYCLES.
  - act[i]=0 clears the counter.
  - qual[i]=1 while count==DEB_CYCLES.
  - A pulse shorter than DEB_CYCLES never trips.
- Latency: fault_in edge to trip_out=1 is exactly 2+DEB_CYCLES clk edges.
- Trip latch, per channel:
  - set when qual[i]=1.
  - clear when ack_in=1 and qual[i]=0.
  - ack_in while qual[i]=1 has no effect on that channel.
  - set and clear in the same cycle: set wins.
- emergency_out: registered OR of the trip set/hold terms; asserts in the same cycle as the first trip_out bit.
- First-fault FSM:
  - IDLE: if any qual bit rises on a channel with trip=0 while all trips are 0, capture the lowest such index into ff_id, set ff_valid=1, go to CAPTURED. Simultaneous qualification on several channels: the lowest index wins.
  - CAPTURED: ff_id is held against later trips. When ack_in=1 and the resulting trip vector is all-zero, clear ff_valid and ff_id, go to IDLE. A channel that qualifies in the same cycle keeps the FSM in CAPTURED with ff_id unchanged.
- Blink counter: free-running over 0..BLINK_HALF-1; blink toggles at wrap.
- lamp_out[i] (registered):
  - trip[i] && !(ff_valid && ff_id==i) gives a steady 1.
  - the first-fault channel gives blink.
  - otherwise 0.
- Trips are not affected by lamp logic. No other reset path exists; ack_in is the only way to clear state after a trip.

Optional Feature:
RPSC_LAMP_TEST_EN:
- Defined: adds input port lamp_test_in (1 bit). While it is 1, all lamp_out bits are 1 starting the next cycle (registered). trip_out, emergency_out, ff_* and the blink counter are unaffected. Releasing it restores normal lamp state the next cycle.
- Undefined: the port is absent and lamps follow normal behaviour only.

Decomposition:
- Package rpsc_pkg: ff_state_e enum (IDLE, CAPTURED), and the function clog2_min1 for ff_id width (min 1).
- One sub-module, rpsc_chan_debounce: synchroniser, polarity and saturating counter for one channel, producing qual. It is instantiated N_CH times in a generate loop.
- Trip latch, FSM, blink and lamps live in the top level.

Test Plan:
- N_CH=8, DEB_CYCLES=4: fault_in[3] held high 3 cycles then low -> no trip, emergency_out stays 0. Held 10 cycles -> trip_out=8'h08 at edge 6, emergency_out=1, ff_valid=1, ff_id=3.
- fault_in[5] and fault_in[2] asserted the same cycle -> ff_id=2. lamp_out[2] blinks (BLINK_HALF=8 in test), lamp_out[5] is steady 1.
- Trip on ch1, then ch6 trips later -> ff_id stays 1. ack_in with ch6 still active -> trip_out=8'h40, ff_valid=1. Ch6 released, then ack -> all 0, FSM back in IDLE.
- ack_in held high while ch0 qualifies -> trip_out[0]=1 (set wins). After release and ack -> 0.
- reset driven low mid-debounce and mid-trip -> all outputs 0 immediately (asynchronous). After release, a fault needs the full 2+DEB_CYCLES again.
- INV_MASK=8'h01, fault_in[0]=0 -> ch0 trips. With RPSC_LAMP_TEST_EN and lamp_test_in=1 -> lamp_out=8'hFF next cycle, trip_out unchanged.
